// File: rtl/aes_ti_pkg.sv
// Shared constants for the byte-serial 2-share TI AES-128 datapath controllers.
// Latency: n/a (constants and a pure combinational helper function).
// Backpressure: n/a.
package aes_ti_pkg;

    typedef logic [4:0] phase_t;

    // One decryption pass always takes this many cycles, final pass included.
    localparam int PASS_LEN = 25;

    localparam phase_t PH_IDLE      = 5'd0;
    localparam phase_t PH_KS_FIRST  = 5'd1;
    localparam phase_t PH_KS_LAST   = 5'd4;
    localparam phase_t PH_ISR       = 5'd5;
    localparam phase_t PH_KA1_FIRST = 5'd6;
    localparam phase_t PH_KA1_LAST  = 5'd9;
    localparam phase_t PH_KA2_FIRST = 5'd10;
    localparam phase_t PH_KA2_LAST  = 5'd17;
    localparam phase_t PH_KA3_FIRST = 5'd18;
    localparam phase_t PH_KA3_LAST  = 5'd21;
    localparam phase_t PH_IMC_FIRST = 5'd22;
    localparam phase_t PH_IMC_LAST  = phase_t'(PASS_LEN);

    // AES field polynomial x^8 + x^4 + x^3 + x + 1.
    localparam logic [8:0] RCON_POLY = 9'h11B;

    // Division by x in GF(2^8): undoes xtime, walking the Rcon sequence backwards.
    function automatic logic [7:0] inv_xtime(input logic [7:0] rcon);
        logic [8:0] tmp;
        tmp = rcon[0] ? ({1'b0, rcon} ^ RCON_POLY) : {1'b0, rcon};
        return tmp[8:1];
    endfunction

endpackage

// File: rtl/aes_dec_rcon.sv
// Inverse round-constant register: loads the last-round Rcon, steps it by inv_xtime.
// Latency: new value visible one cycle after a load or step request.
// Backpressure: none; load/step are single-cycle enables from the sequencer.
module aes_dec_rcon
    import aes_ti_pkg::*;
#(
    parameter logic [7:0] RCON_INIT = 8'h36
) (
    input  logic       ClkxCI,
    input  logic       RstxBI,
    input  logic       LoadxSI,
    input  logic       StepxSI,
    output logic [7:0] RconxDO
);

    logic [7:0] RconxDP;
    logic [7:0] RconxDN;

    // Load wins over step; the sequencer never asks for both in one cycle.
    always_comb begin
        RconxDN = RconxDP;
        if (LoadxSI) begin
            RconxDN = RCON_INIT;
        end else if (StepxSI) begin
            RconxDN = inv_xtime(RconxDP);
        end
    end

    // Rcon state register.
    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            RconxDP <= RCON_INIT;
        end else begin
            RconxDP <= RconxDN;
        end
    end

    assign RconxDO = RconxDP;

endmodule

// File: rtl/aes_dec_ctrl.sv
// Sequencer for the TI AES-128 inverse cipher: phase/round counters, Rcon, phase strobes.
// Latency: start-sampling edge to DonexSO = NROUNDS*PASS_LEN edges; next start accepted in the Done cycle.
// Backpressure: none; StartxSI is only honoured in IDLE and ignored while busy.
module aes_dec_ctrl
    import aes_ti_pkg::*;
#(
    parameter int         NROUNDS   = 10,
    parameter logic [7:0] RCON_INIT = 8'h36
) (
    input  logic       ClkxCI,
    input  logic       RstxBI,
    input  logic       StartxSI,
    output logic       BusyxSO,
    output logic       DonexSO,
    output logic       StateIDLExS,
    output logic       StateLOADxS,
    output logic       StateKEYSCHEDULExS,
    output logic       StateINVSHIFTROWSxS,
    output logic       StateKEYADDITION1o3xS,
    output logic       StateKEYADDITION2o3xS,
    output logic       StateKEYADDITION3o3xS,
    output logic       doInvMixColumnsxS,
    output logic       LastRoundxSO,
    output logic [3:0] RoundxDO,
    output logic [7:0] RconxDO
);

    phase_t     PhasexDP, PhasexDN;
    logic [3:0] RoundxDP, RoundxDN;
    logic       DonexDP,  DonexDN;
    logic       RconLoadxS;
    logic       RconStepxS;
    logic       IsLastxS;

    assign IsLastxS = (RoundxDP == 4'd1);

    // Next-state logic: advance one phase per cycle, wrap or finish at the end of a pass.
    always_comb begin
        PhasexDN   = PhasexDP;
        RoundxDN   = RoundxDP;
        DonexDN    = 1'b0;
        RconLoadxS = 1'b0;
        RconStepxS = 1'b0;
        if (PhasexDP == PH_IDLE) begin
            if (StartxSI) begin
                PhasexDN   = PH_KS_FIRST;
                RoundxDN   = 4'(NROUNDS);
                RconLoadxS = 1'b1;
            end
        end else if (PhasexDP < PH_IMC_LAST) begin
            PhasexDN = PhasexDP + 5'd1;
            // Next pass's key derivation needs the following Rcon, so step once the
            // key schedule of this pass has consumed the current one.
            if (PhasexDP == PH_KS_LAST) begin
                RconStepxS = 1'b1;
            end
        end else if (PhasexDP == PH_IMC_LAST) begin
            if (IsLastxS) begin
                PhasexDN = PH_IDLE;
                RoundxDN = 4'd0;
                DonexDN  = 1'b1;
            end else begin
                PhasexDN = PH_KS_FIRST;
                RoundxDN = RoundxDP - 4'd1;
            end
        end else begin
            // Unreachable codes: recover quietly without claiming a result.
            PhasexDN = PH_IDLE;
            RoundxDN = 4'd0;
        end
    end

    // State registers: phase, round and the Done pulse.
    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            PhasexDP <= PH_IDLE;
            RoundxDP <= 4'd0;
            DonexDP  <= 1'b0;
        end else begin
            PhasexDP <= PhasexDN;
            RoundxDP <= RoundxDN;
            DonexDP  <= DonexDN;
        end
    end

    aes_dec_rcon #(
        .RCON_INIT (RCON_INIT)
    ) u_rcon (
        .ClkxCI  (ClkxCI),
        .RstxBI  (RstxBI),
        .LoadxSI (RconLoadxS),
        .StepxSI (RconStepxS),
        .RconxDO (RconxDO)
    );

    // Phase strobes are pure decodes of the registered phase and round.
    assign StateIDLExS           = (PhasexDP == PH_IDLE);
    assign StateLOADxS           = StateIDLExS && StartxSI;
    assign StateKEYSCHEDULExS    = (PhasexDP >= PH_KS_FIRST)  && (PhasexDP <= PH_KS_LAST);
    assign StateINVSHIFTROWSxS   = (PhasexDP == PH_ISR);
    assign StateKEYADDITION1o3xS = (PhasexDP >= PH_KA1_FIRST) && (PhasexDP <= PH_KA1_LAST);
    assign StateKEYADDITION2o3xS = (PhasexDP >= PH_KA2_FIRST) && (PhasexDP <= PH_KA2_LAST);
    assign StateKEYADDITION3o3xS = (PhasexDP >= PH_KA3_FIRST) && (PhasexDP <= PH_KA3_LAST);
    // The last pass skips InvMixColumns but keeps its slot so every pass is equal length.
    assign doInvMixColumnsxS     = (PhasexDP >= PH_IMC_FIRST) && (PhasexDP <= PH_IMC_LAST) && !IsLastxS;

    assign BusyxSO      = !StateIDLExS;
    assign DonexSO      = DonexDP;
    assign LastRoundxSO = IsLastxS;
    assign RoundxDO     = RoundxDP;

endmodule
